// File: rtl/regfile_dump.sv
// Walks every register-file address through the shared read port and streams
// {address, data} beats on a valid/ready interface, summing the sent data.
module regfile_dump #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int REG_COUNT  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] checksum
);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(REG_COUNT - 1);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  hs;

    // Checksum is a plain modular sum; overflow wraps by design.
    function automatic logic [DATA_WIDTH-1:0] wrap_add(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        return a + b;
    endfunction

    assign hs   = m_valid & m_ready;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = SEND;
            SEND:    if (hs) state_nxt = m_last ? DONE : LOAD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            rd_addr  <= '0;
            m_valid  <= 1'b0;
            m_addr   <= '0;
            m_data   <= '0;
            m_last   <= 1'b0;
            done     <= 1'b0;
            checksum <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx      <= '0;
                        rd_addr  <= '0;
                        checksum <= '0;
                    end
                end
                // rd_addr has been stable for a full cycle here, so rd_data is the settled read
                LOAD: begin
                    m_data  <= rd_data;
                    m_addr  <= idx;
                    m_last  <= (idx == LAST_IDX);
                    m_valid <= 1'b1;
                end
                SEND: begin
                    if (hs) begin
                        checksum <= wrap_add(checksum, m_data);
                        m_valid  <= 1'b0;
                        if (m_last) begin
                            done <= 1'b1;
                        end else begin
                            idx     <= idx + ADDR_WIDTH'(1);
                            rd_addr <= idx + ADDR_WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    m_last <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: a register-file model feeds the read port,
// expected beats are queued at start and compared on every handshake.
module tb_regfile_dump;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 32;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          m_valid;
    logic          m_ready;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          done;
    logic [DW-1:0] checksum;

    logic [DW-1:0] regs [N];
    beat_t         q [$];
    beat_t         prev_beat;
    logic          prev_stall;
    logic          rnd;
    int            cyc;
    int            t_start;
    int            done_cnt;
    int            done_cyc;
    int            n_checks;
    int            n_err;

    regfile_dump #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_COUNT(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_addr   (m_addr),
        .m_data   (m_data),
        .m_last   (m_last),
        .done     (done),
        .checksum (checksum)
    );

    assign rd_data = regs[rd_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: beats are compared on the falling edge before the accepting rising edge.
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", 64'({m_valid, m_addr, m_data}), 64'({1'b1, prev_beat.a, prev_beat.d}));
            if (m_valid && m_ready) begin
                if (q.size() == 0) begin
                    chk("extra_beat", 64'(m_addr), 64'(1 << AW));
                end else begin
                    e = q.pop_front();
                    chk("beat", 64'({m_addr, m_data, m_last}), 64'(e));
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_beat  = '{a: m_addr, d: m_data, l: m_last};
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input bit wr7, output logic [DW-1:0] sum);
        logic [DW-1:0] d;
        sum = '0;
        for (int i = 0; i < N; i++) begin
            d = (wr7 && i == 7) ? 32'hDEAD : regs[i];
            q.push_back('{a: AW'(i), d: d, l: (i == N - 1)});
            sum = sum + d;
        end
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        t_start = cyc;
        chk("busy_rise", 64'(busy), 64'(1));
        chk("csum_clear", 64'(checksum), 64'(0));
    endtask

    task automatic wait_beat(input int a);
        int k;
        k = 0;
        while (!(m_valid && m_addr == AW'(a)) && k < 2000) begin
            tick();
            k++;
        end
        chk("beat_reached", 64'(k < 2000), 64'(1));
    endtask

    task automatic run_dump(input bit restart5, input bit wr7, input bit chk_lat);
        logic [DW-1:0] sum;
        int base;
        int k;
        push_exp(wr7, sum);
        base = done_cnt;
        pulse_start();
        if (restart5) begin
            wait_beat(5);
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        if (wr7) begin
            wait_beat(3);
            regs[7] = 32'hDEAD;
        end
        k = 0;
        while (done_cnt == base && k < 5000) begin
            tick();
            k++;
        end
        chk("done_seen", 64'(done_cnt - base), 64'(1));
        if (chk_lat) chk("done_latency", 64'(done_cyc - t_start), 64'(2 * N));
        chk("csum", 64'(checksum), 64'(sum));
        chk("all_beats", 64'(q.size()), 64'(0));
        tick();
        chk("busy_fall", 64'(busy), 64'(0));
        chk("idle_outputs", 64'({m_valid, m_last, done}), 64'(0));
        chk("csum_hold", 64'(checksum), 64'(sum));
        repeat (4) tick();
        chk("done_once", 64'(done_cnt - base), 64'(1));
        chk("no_restart", 64'(busy), 64'(0));
    endtask

    initial begin
        logic [DW-1:0] s;
        int base;
        n_checks = 0;
        n_err    = 0;
        done_cnt = 0;
        done_cyc = 0;
        cyc      = 0;
        t_start  = 0;
        rnd      = 1'b0;
        start    = 1'b0;
        rst_n    = 1'b0;
        prev_stall = 1'b0;
        for (int i = 0; i < N; i++) regs[i] = 32'(i * 3 + 1);

        repeat (3) tick();
        chk("rst_ctrl", 64'({busy, m_valid, m_last, done}), 64'(0));
        chk("rst_addr", 64'({rd_addr, m_addr}), 64'(0));
        chk("rst_data", 64'({m_data, checksum}), 64'(0));
        rst_n = 1'b1;
        tick();

        run_dump(1'b0, 1'b0, 1'b1);

        rnd = 1'b1;
        run_dump(1'b0, 1'b0, 1'b0);
        rnd = 1'b0;
        tick();

        for (int i = 0; i < N; i++) regs[i] = 32'hFFFF_FFFF;
        run_dump(1'b0, 1'b0, 1'b1);
        chk("csum_wrap", 64'(checksum), 64'(32'hFFFF_FFE0));

        for (int i = 0; i < N; i++) regs[i] = 32'(i * 3 + 1);
        run_dump(1'b1, 1'b0, 1'b1);
        run_dump(1'b0, 1'b0, 1'b1);

        push_exp(1'b0, s);
        pulse_start();
        wait_beat(10);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(m_valid), 64'(0));
        chk("rst_mid_busy", 64'(busy), 64'(0));
        chk("rst_mid_csum", 64'(checksum), 64'(0));
        chk("rst_mid_addr", 64'(rd_addr), 64'(0));
        q.delete();
        base = done_cnt;
        repeat (4) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("rst_no_done", 64'(done_cnt - base), 64'(0));
        run_dump(1'b0, 1'b0, 1'b1);

        run_dump(1'b0, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
